// File: rtl/debug_dump_sequencer_if.sv
// Byte-wide send handshake between the dump sequencer and the UART transmitter.
// The sequencer pulses tx_start with tx_data valid; the transmitter answers with tx_done.
interface debug_dump_sequencer_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               tx_done;

    modport master (output tx_data, output tx_start, input tx_done);
    modport slave  (input tx_data, input tx_start, output tx_done);
endinterface

// File: rtl/debug_dump_sequencer.sv
// Dumps logged data-memory words, the 32 GPRs and the packed pipeline latches byte-wise over UART TX.
// Optional macro DUMP_MEM_ADDR_EN prefixes each memory record with its word address byte.
module debug_dump_sequencer #(
    parameter int NB_DATA     = 8,
    parameter int NB_LATCHES  = 360,
    parameter int NB_MEM_ADDR = 5,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_send_mem,
    input  logic                   i_mem_write,
    input  logic [31:0]            i_mem_addr,
    input  logic [31:0]            i_r_data_registers,
    input  logic [31:0]            i_r_data_data_mem,
    input  logic [NB_LATCHES-1:0]  i_latches,
    debug_dump_sequencer_if.master tx,
    output logic [4:0]             o_r_addr_registers,
    output logic [NB_MEM_ADDR-1:0] o_r_addr_data_mem,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overflow
);
    localparam int LAT_BYTES = (NB_LATCHES + NB_DATA - 1) / NB_DATA;
    localparam int SHIFT_W   = LAT_BYTES * NB_DATA;
    localparam int CNT_W     = $clog2(LAT_BYTES + 1);
    localparam int PW        = $clog2(FIFO_DEPTH);
`ifdef DUMP_MEM_ADDR_EN
    localparam int MEM_REC_W = NB_DATA + 32;
`else
    localparam int MEM_REC_W = 32;
`endif
    localparam int MEM_BYTES = MEM_REC_W / NB_DATA;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {SEC_MEM, SEC_REG, SEC_LAT} sect_t;

    state_t                 r_state, w_state_nxt;
    sect_t                  r_sect, w_sect_nxt;
    logic [SHIFT_W-1:0]     r_shift;
    logic [SHIFT_W-1:0]     w_load_val;
    logic [CNT_W-1:0]       r_bytes_left;
    logic [CNT_W-1:0]       w_load_cnt;
    logic [4:0]             r_reg_idx;
    logic [NB_MEM_ADDR-1:0] r_fifo [FIFO_DEPTH];
    logic [PW:0]            r_wptr, r_rptr;
    logic                   r_overflow;
    logic                   w_full, w_empty;
    logic [NB_MEM_ADDR-1:0] w_head;
    logic [MEM_REC_W-1:0]   w_mem_rec;
    logic                   w_unused_addr;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_head  = r_fifo[r_rptr[PW-1:0]];
    assign w_unused_addr = ^{i_mem_addr[31:NB_MEM_ADDR+2], i_mem_addr[1:0]};

`ifdef DUMP_MEM_ADDR_EN
    assign w_mem_rec = {NB_DATA'(w_head), i_r_data_data_mem};
`else
    assign w_mem_rec = i_r_data_data_mem;
`endif

    // Every item is left-aligned in the shift register so its MS byte is always on top.
    always_comb begin
        w_load_val = '0;
        w_load_cnt = '0;
        case (r_sect)
            SEC_MEM: begin
                w_load_val = SHIFT_W'(w_mem_rec) << (SHIFT_W - MEM_REC_W);
                w_load_cnt = CNT_W'(MEM_BYTES);
            end
            SEC_REG: begin
                w_load_val = SHIFT_W'(i_r_data_registers) << (SHIFT_W - 32);
                w_load_cnt = CNT_W'(4);
            end
            default: begin
                w_load_val = SHIFT_W'(i_latches);
                w_load_cnt = CNT_W'(LAT_BYTES);
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sect_nxt  = r_sect;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                    w_sect_nxt  = (i_send_mem && !w_empty) ? SEC_MEM : SEC_REG;
                end
            end
            S_LOAD:  w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (tx.tx_done) begin
                    if (r_bytes_left > CNT_W'(1)) begin
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_LOAD;
                        case (r_sect)
                            SEC_MEM: if (w_empty) w_sect_nxt = SEC_REG;
                            SEC_REG: if (r_reg_idx == 5'd31) w_sect_nxt = SEC_LAT;
                            default: w_state_nxt = S_DONE;
                        endcase
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_sect       <= SEC_MEM;
            r_shift      <= '0;
            r_bytes_left <= '0;
            r_reg_idx    <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sect  <= w_sect_nxt;
            if (r_state == S_IDLE && i_mem_write) begin
                if (w_full) r_overflow <= 1'b1;
                else        r_wptr     <= r_wptr + 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_shift      <= w_load_val;
                r_bytes_left <= w_load_cnt;
                if (r_sect == SEC_MEM) r_rptr <= r_rptr + 1'b1;
            end
            // The register index wraps back to 0 after r31, ready for the next dump.
            if (r_state == S_WAIT && tx.tx_done) begin
                r_shift      <= r_shift << NB_DATA;
                r_bytes_left <= r_bytes_left - 1'b1;
                if (r_bytes_left == CNT_W'(1) && r_sect == SEC_REG) r_reg_idx <= r_reg_idx + 1'b1;
            end
            if (r_state == S_DONE) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_mem_write && !w_full)
            r_fifo[r_wptr[PW-1:0]] <= i_mem_addr[NB_MEM_ADDR+1:2];
    end

    assign o_r_addr_data_mem  = (r_state == S_LOAD && r_sect == SEC_MEM) ? w_head : '0;
    assign o_r_addr_registers = (r_state == S_LOAD && r_sect == SEC_REG) ? r_reg_idx : '0;
    assign tx.tx_data  = (r_state == S_START || r_state == S_WAIT) ? r_shift[SHIFT_W-1 -: NB_DATA] : '0;
    assign tx.tx_start = (r_state == S_START);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_overflow  = r_overflow;
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Randomized bench for debug_dump_sequencer: the expected byte stream of each dump is built from
// the logged addresses, GPR/memory images and latches, and every sent byte is checked against it.
module tb_debug_dump_sequencer;
    localparam int NB_LATCHES = 360;
    localparam int LAT_BYTES  = (NB_LATCHES + 7) / 8;
`ifdef DUMP_MEM_ADDR_EN
    localparam int REC_BYTES = 5;
`else
    localparam int REC_BYTES = 4;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_start = 1'b0, i_send_mem = 1'b0, i_mem_write = 1'b0;
    logic [31:0]           i_mem_addr = '0;
    logic [31:0]           i_r_data_registers, i_r_data_data_mem;
    logic [NB_LATCHES-1:0] lat = '0;
    logic                  tb_tx_done = 1'b0;
    logic [4:0]            o_r_addr_registers, o_r_addr_data_mem;
    logic                  o_busy, o_done, o_overflow;

    logic [31:0] regs [32];
    logic [31:0] dmem [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  obs_q [$];
    logic [4:0]  log_q [$];
    bit          m_ovf = 1'b0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    debug_dump_sequencer_if #(.NB_DATA(8)) tx_if ();
    assign tx_if.tx_done = tb_tx_done;
    assign i_r_data_registers = regs[o_r_addr_registers];
    assign i_r_data_data_mem  = dmem[o_r_addr_data_mem];

    debug_dump_sequencer dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_send_mem(i_send_mem),
        .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_r_data_registers(i_r_data_registers), .i_r_data_data_mem(i_r_data_data_mem),
        .i_latches(lat), .tx(tx_if),
        .o_r_addr_registers(o_r_addr_registers), .o_r_addr_data_mem(o_r_addr_data_mem),
        .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic build_expected(input bit send_mem);
        logic [LAT_BYTES*8-1:0] pad;
        exp_q.delete();
        if (send_mem && log_q.size() != 0) begin
            foreach (log_q[k]) begin
`ifdef DUMP_MEM_ADDR_EN
                exp_q.push_back({3'b000, log_q[k]});
`endif
                for (int b = 3; b >= 0; b--) exp_q.push_back(dmem[log_q[k]][8*b +: 8]);
            end
        end
        for (int r = 0; r < 32; r++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(regs[r][8*b +: 8]);
        pad = (LAT_BYTES*8)'(lat);
        for (int b = LAT_BYTES - 1; b >= 0; b--) exp_q.push_back(pad[8*b +: 8]);
    endtask

    task automatic write_mem(input logic [31:0] a);
        @(negedge clk);
        i_mem_write = 1'b1;
        i_mem_addr  = a;
        if (log_q.size() < 16) log_q.push_back(a[6:2]);
        else m_ovf = 1'b1;
        @(negedge clk);
        i_mem_write = 1'b0;
    endtask

    task automatic do_dump(input bit send_mem, input bit noise, input int abort_after);
        int  acked, wait_cnt, done_due;
        bit  pending, finished, aborted, fresh;
        @(negedge clk);
        chk("idle_before_dump", o_busy, 0);
        chk("overflow_before_dump", o_overflow, m_ovf);
        build_expected(send_mem);
        obs_q.delete();
        i_start = 1'b1;
        i_send_mem = send_mem;
        @(negedge clk);
        i_start = 1'b0;
        chk("no_start_in_load", tx_if.tx_start, 0);
        chk("busy_in_dump", o_busy, 1);
        @(negedge clk);
        chk("first_start_latency", tx_if.tx_start, 1);
        pending = 0; acked = 0; wait_cnt = 0; done_due = -1; finished = 0; aborted = 0;
        for (int cyc = 0; cyc < 20000 && !finished && !aborted; cyc++) begin
            fresh = 0;
            if (pending) begin
                chk("no_start_while_waiting", tx_if.tx_start, 0);
                chk("tx_data_hold", tx_if.tx_data, obs_q[obs_q.size()-1]);
            end else if (tx_if.tx_start) begin
                if (obs_q.size() < exp_q.size()) chk("tx_byte", tx_if.tx_data, exp_q[obs_q.size()]);
                else chk("no_extra_byte", tx_if.tx_start, 0);
                obs_q.push_back(tx_if.tx_data);
                pending = 1; fresh = 1;
                wait_cnt = $urandom_range(0, 3);
            end
            if (cyc == done_due) begin
                chk("done_pulse", o_done, 1);
                finished = 1;
            end else begin
                chk("no_early_done", o_done, 0);
            end
            tb_tx_done = 1'b0; i_start = 1'b0; i_mem_write = 1'b0;
            if (pending && !fresh) begin
                if (wait_cnt == 0) begin
                    tb_tx_done = 1'b1;
                    pending = 0;
                    acked++;
                    if (acked == abort_after) begin
                        rst = 1'b1;
                        aborted = 1;
                    end else if (acked == exp_q.size()) begin
                        done_due = cyc + 1;
                    end
                end else begin
                    wait_cnt--;
                end
            end else if (noise && done_due < 0) begin
                tb_tx_done  = ($urandom_range(0, 2) == 0);
                i_start     = ($urandom_range(0, 2) == 0);
                i_send_mem  = 1'($urandom);
                i_mem_write = ($urandom_range(0, 2) == 0);
                i_mem_addr  = $urandom;
            end
            @(negedge clk);
        end
        tb_tx_done = 1'b0; i_start = 1'b0; i_mem_write = 1'b0;
        log_q.delete();
        m_ovf = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
            repeat (8) begin
                @(negedge clk);
                chk("abort_no_start", tx_if.tx_start, 0);
                chk("abort_not_busy", o_busy, 0);
            end
            chk("abort_byte_count", obs_q.size(), abort_after);
            chk("abort_overflow_clear", o_overflow, 0);
        end else begin
            if (!finished) chk("dump_finished_in_budget", o_busy, 0);
            chk("byte_count", obs_q.size(), exp_q.size());
            chk("idle_after_done", o_busy, 0);
            chk("overflow_clear_after_done", o_overflow, 0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) begin
            regs[r] = $urandom;
            dmem[r] = $urandom;
        end
        regs[1] = 32'hDEADBEEF;
        dmem[3] = 32'h11223344;
        dmem[4] = 32'h55667788;
        for (int k = 0; k < NB_LATCHES / 8; k++) lat[8*k +: 8] = 8'($urandom);
        lat[359:352] = 8'hA5;
        lat[7:0]     = 8'h3C;

        repeat (3) @(negedge clk);
        chk("reset_tx_start", tx_if.tx_start, 0);
        chk("reset_tx_data", tx_if.tx_data, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_overflow", o_overflow, 0);
        chk("reset_reg_addr", o_r_addr_registers, 0);
        chk("reset_mem_addr", o_r_addr_data_mem, 0);
        rst = 1'b0;

        // Two logged writes with the memory section enabled.
        write_mem(32'h0000_000F);
        write_mem(32'h0000_0013);
        do_dump(1, 0, -1);
`ifdef DUMP_MEM_ADDR_EN
        chk("t1_count", obs_q.size(), 183);
        chk("t1_first_byte", obs_q[0], 8'h03);
        chk("t1_mem0_msb", obs_q[1], 8'h11);
        chk("t1_rec1_addr", obs_q[5], 8'h04);
`else
        chk("t1_count", obs_q.size(), 181);
        chk("t1_first_byte", obs_q[0], 8'h11);
        chk("t1_mem0_lsb", obs_q[3], 8'h44);
        chk("t1_rec1_msb", obs_q[4], 8'h55);
`endif
        chk("t1_lat_first", obs_q[REC_BYTES*2 + 128], 8'hA5);
        chk("t1_lat_last", obs_q[obs_q.size()-1], 8'h3C);

        // Memory section skipped even with a logged write.
        write_mem(32'h0000_0040);
        do_dump(0, 1, -1);
        chk("t2_count", obs_q.size(), 173);
        chk("t2_r1_b0", obs_q[4], 8'hDE);
        chk("t2_r1_b1", obs_q[5], 8'hAD);
        chk("t2_r1_b2", obs_q[6], 8'hBE);
        chk("t2_r1_b3", obs_q[7], 8'hEF);

        // Log overflow: 17 writes keep 16 records.
        for (int k = 0; k < 17; k++) write_mem($urandom);
        @(negedge clk);
        chk("t3_overflow_set", o_overflow, 1);
        do_dump(1, 1, -1);
        chk("t3_count", obs_q.size(), 16*REC_BYTES + 173);

        // Memory section requested with an empty log.
        do_dump(1, 1, -1);
        chk("t4_count", obs_q.size(), 173);

        // Reset after 10 bytes, then a clean restart from byte 0.
        for (int k = 0; k < 3; k++) write_mem($urandom);
        do_dump(1, 1, 10);
        do_dump(1, 0, -1);
        chk("t5_count", obs_q.size(), 173);
        chk("t5_r1_b0", obs_q[4], 8'hDE);

        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < 32; r++) begin
                regs[r] = $urandom;
                dmem[r] = $urandom;
            end
            for (int k = 0; k < NB_LATCHES / 8; k++) lat[8*k +: 8] = 8'($urandom);
            for (int k = $urandom_range(0, 20); k > 0; k--) write_mem($urandom);
            do_dump(1'($urandom), 1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
